// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the i_cache/d_cache memory-port arbiter.
// State codes stay plain localparams so existing decode logic can keep comparing raw values.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_OWN_I = 2'd1;
  localparam logic [1:0] ARB_OWN_D = 2'd2;
  localparam logic [1:0] ARB_DRAIN = 2'd3;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] SEL_WORD  = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Registered grant FSM sharing the axi_interface cache port between i_cache and d_cache.
// Grant is locked until the owner's access completes; a starve counter bounds priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int D_PRIORITY = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_strobe,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  input  logic        d_strobe,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wen,
  output logic        d_ready,
  output logic        mem_access,
  output logic        mem_write,
  output logic [31:0] mem_a,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  input  logic        mem_ready,
  output logic        grant_i,
  output logic        grant_d
);

  localparam logic [1:0] PRI_OWN  = (D_PRIORITY != 0) ? ARB_OWN_D : ARB_OWN_I;
  localparam logic [1:0] LOSE_OWN = (D_PRIORITY != 0) ? ARB_OWN_I : ARB_OWN_D;
  localparam logic [3:0] LIM      = 4'(STARVE_LIM);

  logic [1:0] state_q, state_d, grant_to;
  logic [3:0] starve_q, starve_d;
  logic       out_q, out_d;
  logic       contested;
  mem_req_t   hold_q, live, req;
  logic       own_i, own_d, own_any, own_strobe, other_strobe, flush_hold;

  assign own_i        = (state_q == ARB_OWN_I);
  assign own_d        = (state_q == ARB_OWN_D);
  assign own_any      = own_i | own_d;
  assign own_strobe   = own_i ? i_strobe : d_strobe;
  assign other_strobe = own_i ? d_strobe : i_strobe;
  // Owner dropped its strobe with an access in flight: keep the AXI request
  // stable this cycle too, so the flush never glitches mem_access low.
  assign flush_hold   = own_any & ~own_strobe & out_q;

  always_comb begin
    live = '0;
    if (own_i)      live = '{addr: i_addr, write: 1'b0, size: SIZE_WORD, sel: SEL_WORD};
    else if (own_d) live = '{addr: d_addr, write: d_rw, size: d_size, sel: d_wen};
  end

  always_comb begin
    req        = live;
    mem_access = own_any & own_strobe;
    if (state_q == ARB_DRAIN || flush_hold) begin
      req        = hold_q;
      mem_access = 1'b1;
    end
  end

  assign mem_a     = req.addr;
  assign mem_write = req.write;
  assign mem_size  = req.size;
  assign mem_sel   = req.sel;
  assign i_ready   = mem_ready & own_i;
  assign d_ready   = mem_ready & own_d;
  assign grant_i   = own_i;
  assign grant_d   = own_d;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    grant_to  = ARB_IDLE;
    contested = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (i_strobe && d_strobe) begin
          grant_to  = (starve_q == LIM) ? LOSE_OWN : PRI_OWN;
          contested = 1'b1;
        end else if (i_strobe) begin
          grant_to = ARB_OWN_I;
        end else if (d_strobe) begin
          grant_to = ARB_OWN_D;
        end
      end
      ARB_OWN_I, ARB_OWN_D: begin
        if (!own_strobe) begin
          if (out_q && !mem_ready) state_d = ARB_DRAIN;
          else if (other_strobe)   grant_to = own_i ? ARB_OWN_D : ARB_OWN_I;
          else                     state_d = ARB_IDLE;
        end
      end
      ARB_DRAIN: if (mem_ready) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
    if (grant_to != ARB_IDLE) begin
      state_d = grant_to;
      if (grant_to == PRI_OWN) begin
        if (contested && starve_q < LIM) starve_d = starve_q + 4'd1;
      end else begin
        starve_d = '0;
      end
    end
  end

  assign out_d = mem_ready ? 1'b0 : (mem_access ? 1'b1 : out_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      out_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      out_q    <= out_d;
      if (own_any && own_strobe) hold_q <= live;
    end
  end

endmodule
